fifo_status_monitor: RTL and testbench

Parametrised multi-channel FIFO health monitor for the receive data path. For each of NCH FIFOs it detects overflow (write while full) and underflow (read while empty) in a single clock domain. Each event sets a sticky flag and increments a saturating counter. The host reads flags and counters through a registered readback port, and an aggregated maskable interrupt is raised. It replaces per-FIFO two-flag monitors once all channel FIFOs sit behind a common system clock.

---
 rtl/fifo_mon_pkg.sv | 24 ++
 rtl/fifo_chan_monitor.sv | 75 +++++++
 rtl/fifo_status_monitor.sv | 82 ++++++++
 tb/tb_fifo_status_monitor.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_mon_pkg.sv
// Shared definitions for the FIFO health monitor: channel limit and
// bit positions of the fields inside one readback word.
package fifo_mon_pkg;

  localparam int MAX_NCH = 16;

  // Readback word layout, MSB first: {ovf_flag, unf_flag, ovf_count, unf_count}
  function automatic int OVF_FLAG_BIT(input int cw);
    return 2 * cw + 1;
  endfunction

  function automatic int UNF_FLAG_BIT(input int cw);
    return 2 * cw;
  endfunction

  function automatic int OVF_CNT_LSB(input int cw);
    return cw;
  endfunction

  function automatic int UNF_CNT_LSB(input int cw);
    return 0;
  endfunction

endpackage

// File: rtl/fifo_chan_monitor.sv
// One channel of the monitor: sticky overflow/underflow flags and their
// saturating event counters.
module fifo_chan_monitor
  import fifo_mon_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ovf_evt,
  input  logic          unf_evt,
  input  logic          clear,
  output logic          ovf_flag,
  output logic          unf_flag,
  output logic [CW-1:0] ovf_count,
  output logic [CW-1:0] unf_count
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          ovf_flag_q, ovf_flag_d;
  logic          unf_flag_q, unf_flag_d;
  logic [CW-1:0] ovf_count_q, ovf_count_d;
  logic [CW-1:0] unf_count_q, unf_count_d;

  // A clear coinciding with an event restarts from that event, so it is never lost.
  always_comb begin
    ovf_flag_d  = ovf_flag_q;
    ovf_count_d = ovf_count_q;
    if (clear) begin
      ovf_flag_d  = ovf_evt;
      ovf_count_d = ovf_evt ? CNT_ONE : '0;
    end else if (ovf_evt) begin
      ovf_flag_d = 1'b1;
      if (ovf_count_q != CNT_MAX) begin
        ovf_count_d = ovf_count_q + CNT_ONE;
      end
    end
  end

  always_comb begin
    unf_flag_d  = unf_flag_q;
    unf_count_d = unf_count_q;
    if (clear) begin
      unf_flag_d  = unf_evt;
      unf_count_d = unf_evt ? CNT_ONE : '0;
    end else if (unf_evt) begin
      unf_flag_d = 1'b1;
      if (unf_count_q != CNT_MAX) begin
        unf_count_d = unf_count_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_flag_q  <= 1'b0;
      unf_flag_q  <= 1'b0;
      ovf_count_q <= '0;
      unf_count_q <= '0;
    end else begin
      ovf_flag_q  <= ovf_flag_d;
      unf_flag_q  <= unf_flag_d;
      ovf_count_q <= ovf_count_d;
      unf_count_q <= unf_count_d;
    end
  end

  assign ovf_flag  = ovf_flag_q;
  assign unf_flag  = unf_flag_q;
  assign ovf_count = ovf_count_q;
  assign unf_count = unf_count_q;

endmodule

// File: rtl/fifo_status_monitor.sv
// Multi-channel FIFO overflow/underflow monitor with registered host
// readback and an aggregated, maskable interrupt.
module fifo_status_monitor
  import fifo_mon_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CW    = 8,
  parameter int SEL_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCH-1:0]      fifo_full,
  input  logic [NCH-1:0]      fifo_empty,
  input  logic [NCH-1:0]      fifo_wr,
  input  logic [NCH-1:0]      fifo_rd,
  input  logic [NCH-1:0]      clear,
  input  logic [NCH-1:0]      irq_mask,
  input  logic [SEL_W-1:0]    rd_sel,
  output logic [2*CW+1:0]     rd_data,
  output logic [NCH-1:0]      ovf_flags,
  output logic [NCH-1:0]      unf_flags,
  output logic                irq
);

  localparam int NCH_EFF = (NCH < MAX_NCH) ? NCH : MAX_NCH;

  logic [CW-1:0] ovf_count [NCH_EFF];
  logic [CW-1:0] unf_count [NCH_EFF];

  logic [2*CW+1:0] rd_data_q, rd_data_d;
  logic            irq_q, irq_d;

  genvar gi;
  generate
    for (gi = 0; gi < NCH_EFF; gi++) begin : g_chan
      fifo_chan_monitor #(
        .CW(CW)
      ) u_chan (
        .clk      (clk),
        .reset    (reset),
        .ovf_evt  (fifo_wr[gi] & fifo_full[gi]),
        .unf_evt  (fifo_rd[gi] & fifo_empty[gi]),
        .clear    (clear[gi]),
        .ovf_flag (ovf_flags[gi]),
        .unf_flag (unf_flags[gi]),
        .ovf_count(ovf_count[gi]),
        .unf_count(unf_count[gi])
      );
    end
  endgenerate

  // Any select outside the populated channels falls through to zero.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NCH_EFF; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_data_d[OVF_FLAG_BIT(CW)]         = ovf_flags[i];
        rd_data_d[UNF_FLAG_BIT(CW)]         = unf_flags[i];
        rd_data_d[OVF_CNT_LSB(CW) +: CW]    = ovf_count[i];
        rd_data_d[UNF_CNT_LSB(CW) +: CW]    = unf_count[i];
      end
    end
  end

  always_comb begin
    irq_d = |((ovf_flags | unf_flags) & irq_mask);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      irq_q     <= irq_d;
    end
  end

  assign rd_data = rd_data_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_fifo_status_monitor.sv
// Self-checking bench for fifo_status_monitor: a cycle model pushes the
// expected post-edge outputs to a queue, which is popped after each edge.
module tb_fifo_status_monitor;

  localparam int NCH   = 4;
  localparam int CW    = 4;
  localparam int SEL_W = 4;
  localparam int RDW   = 2 * CW + 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NCH-1:0]   fifo_full, fifo_empty, fifo_wr, fifo_rd, clear, irq_mask;
  logic [SEL_W-1:0] rd_sel;
  logic [RDW-1:0]   rd_data;
  logic [NCH-1:0]   ovf_flags, unf_flags;
  logic             irq;

  always #5 clk = ~clk;

  fifo_status_monitor #(
    .NCH  (NCH),
    .CW   (CW),
    .SEL_W(SEL_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty),
    .fifo_wr   (fifo_wr),
    .fifo_rd   (fifo_rd),
    .clear     (clear),
    .irq_mask  (irq_mask),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .ovf_flags (ovf_flags),
    .unf_flags (unf_flags),
    .irq       (irq)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference state of every channel
  logic          m_ovf [NCH];
  logic          m_unf [NCH];
  logic [CW-1:0] m_ovf_cnt [NCH];
  logic [CW-1:0] m_unf_cnt [NCH];

  typedef struct {
    logic [RDW-1:0] rd;
    logic [NCH-1:0] ovf;
    logic [NCH-1:0] unf;
    logic           irq;
  } exp_t;

  exp_t sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one clock with the current inputs, predict, then compare after the edge.
  task automatic cycle();
    exp_t e;
    logic [NCH-1:0] pre_flags;
    int s;
    s = int'(rd_sel);
    pre_flags = '0;
    e.rd = '0;
    for (int i = 0; i < NCH; i++) pre_flags[i] = m_ovf[i] | m_unf[i];
    if (!reset && s < NCH) e.rd = {m_ovf[s], m_unf[s], m_ovf_cnt[s], m_unf_cnt[s]};
    e.irq = !reset && (|(pre_flags & irq_mask));
    for (int i = 0; i < NCH; i++) begin
      logic oe, ue;
      oe = fifo_wr[i] & fifo_full[i];
      ue = fifo_rd[i] & fifo_empty[i];
      if (reset) begin
        m_ovf[i] = 1'b0; m_unf[i] = 1'b0; m_ovf_cnt[i] = '0; m_unf_cnt[i] = '0;
      end else if (clear[i]) begin
        m_ovf[i] = oe; m_ovf_cnt[i] = oe ? CW'(1) : '0;
        m_unf[i] = ue; m_unf_cnt[i] = ue ? CW'(1) : '0;
      end else begin
        if (oe) begin
          m_ovf[i] = 1'b1;
          if (m_ovf_cnt[i] != {CW{1'b1}}) m_ovf_cnt[i] = m_ovf_cnt[i] + 1'b1;
        end
        if (ue) begin
          m_unf[i] = 1'b1;
          if (m_unf_cnt[i] != {CW{1'b1}}) m_unf_cnt[i] = m_unf_cnt[i] + 1'b1;
        end
      end
      e.ovf[i] = m_ovf[i];
      e.unf[i] = m_unf[i];
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_underrun", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check_eq("sb_rd_data", 32'(rd_data), 32'(e.rd));
      check_eq("sb_ovf_flags", 32'(ovf_flags), 32'(e.ovf));
      check_eq("sb_unf_flags", 32'(unf_flags), 32'(e.unf));
      check_eq("sb_irq", 32'(irq), 32'(e.irq));
    end
  endtask

  task automatic idle_inputs();
    fifo_full = '0; fifo_empty = '0; fifo_wr = '0; fifo_rd = '0; clear = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NCH; i++) begin
      m_ovf[i] = 1'b0; m_unf[i] = 1'b0; m_ovf_cnt[i] = '0; m_unf_cnt[i] = '0;
    end
    idle_inputs();
    irq_mask = '0;
    rd_sel   = '0;
    reset    = 1'b1;

    // Reset then idle
    repeat (2) cycle();
    reset = 1'b0;
    for (int s = 0; s < NCH; s++) begin
      rd_sel = SEL_W'(s);
      cycle();
      check_eq($sformatf("reset_rd_data_ch%0d", s), 32'(rd_data), 32'd0);
    end
    check_eq("reset_flags", 32'({ovf_flags, unf_flags, irq}), 32'd0);

    // Overflow burst on channel 2
    fifo_full[2] = 1'b1; fifo_wr[2] = 1'b1;
    repeat (5) cycle();
    idle_inputs();
    rd_sel = 2;
    cycle();
    check_eq("ovf_ch2_rd", 32'(rd_data), 32'({1'b1, 1'b0, 4'd5, 4'd0}));
    check_eq("ovf_ch2_flags", 32'(ovf_flags), 32'h4);
    rd_sel = 1;
    cycle();
    check_eq("ovf_ch1_untouched", 32'(rd_data), 32'd0);

    // Underflow saturation on channel 0
    fifo_rd[0] = 1'b1; fifo_empty[0] = 1'b1;
    repeat (20) cycle();
    idle_inputs();
    rd_sel = 0;
    repeat (3) cycle();
    check_eq("sat_ch0_rd", 32'(rd_data), 32'({1'b0, 1'b1, 4'd0, 4'd15}));
    check_eq("sat_ch0_unf_flag", 32'(unf_flags[0]), 32'd1);

    // Clear colliding with an overflow event on channel 1
    fifo_full[1] = 1'b1; fifo_wr[1] = 1'b1;
    repeat (7) cycle();
    rd_sel = 1;
    idle_inputs();
    cycle();
    check_eq("clr_pre_rd", 32'(rd_data), 32'({1'b1, 1'b0, 4'd7, 4'd0}));
    fifo_full[1] = 1'b1; fifo_wr[1] = 1'b1; clear[1] = 1'b1;
    cycle();
    idle_inputs();
    clear[1] = 1'b1;
    cycle();
    check_eq("clr_collision_rd", 32'(rd_data), 32'({1'b1, 1'b0, 4'd1, 4'd0}));
    idle_inputs();
    cycle();
    check_eq("clr_alone_rd", 32'(rd_data), 32'd0);
    check_eq("clr_irq_masked", 32'(irq), 32'd0);

    // Interrupt masking on channel 3
    fifo_rd[3] = 1'b1; fifo_empty[3] = 1'b1;
    cycle();
    idle_inputs();
    repeat (2) cycle();
    check_eq("irq_masked", 32'(irq), 32'd0);
    check_eq("irq_unf_flag3", 32'(unf_flags[3]), 32'd1);
    irq_mask[3] = 1'b1;
    cycle();
    check_eq("irq_rise", 32'(irq), 32'd1);
    clear[3] = 1'b1;
    cycle();
    clear[3] = 1'b0;
    check_eq("irq_hold_after_clr", 32'(irq), 32'd1);
    cycle();
    check_eq("irq_fall", 32'(irq), 32'd0);

    // Out-of-range select and simultaneous ovf/unf on one channel
    rd_sel = 5;
    cycle();
    check_eq("sel_oor_rd", 32'(rd_data), 32'd0);
    fifo_full[3] = 1'b1; fifo_wr[3] = 1'b1; fifo_rd[3] = 1'b1; fifo_empty[3] = 1'b1;
    repeat (2) cycle();
    idle_inputs();
    rd_sel = 3;
    cycle();
    check_eq("both_ch3_rd", 32'(rd_data), 32'({1'b1, 1'b1, 4'd2, 4'd2}));

    // Reset in the middle of an overflow burst on all channels
    fifo_full = '1; fifo_wr = '1;
    repeat (3) cycle();
    reset = 1'b1;
    cycle();
    check_eq("midrst_flags", 32'({ovf_flags, unf_flags, irq}), 32'd0);
    check_eq("midrst_rd", 32'(rd_data), 32'd0);
    reset = 1'b0;
    cycle();
    idle_inputs();
    rd_sel = 2;
    cycle();
    check_eq("midrst_restart_rd", 32'(rd_data), 32'({1'b1, 1'b0, 4'd1, 4'd0}));
    check_eq("midrst_restart_flags", 32'(ovf_flags), 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
